// File: rtl/rs_pkg.sv
// Shared rename/result definitions for the reservation-station and CDB logic.
// Tag value TAG_NONE means "no producer" and is never broadcast.
package rs_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int NUM_FU = 4;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    // Functional-unit result port indices on the CDB.
    localparam int FU_ADD = 0;
    localparam int FU_MUL = 1;
    localparam int FU_LD  = 2;
    localparam int FU_ST  = 3;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } result_t;

    // Next index after i in a ring of n entries.
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin arbiter: picks one request starting at rr_ptr, searching upward with wrap.
// Latency: grant is combinational from req; rr_ptr updates on the edge after a grant.
// Backpressure: none; a zero request vector yields no grant and rr_ptr holds.
module rr_arbiter
    import rs_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;
    logic          any;

    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(rr_ptr) + k) % N);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (any) begin
            rr_ptr <= PW'(wrap_inc(int'(gidx), N));
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus: per-FU holding buffers, round-robin pick, registered broadcast.
// Latency: handshake N -> buffer full N+1 -> cdb_valid N+2 when granted first try.
// Backpressure: src_ready = ~full | grant (0 during flush); CDB_PERF_EN adds perf counters.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = rs_pkg::TAG_W,
    parameter int DATA_W  = rs_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data
`ifdef CDB_PERF_EN
    ,
    output logic [15:0]               perf_bcast,
    output logic [15:0]               perf_conflict
`endif
);
    import rs_pkg::*;

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] take;
    logic [TAG_W-1:0]   buf_tag  [NUM_SRC];
    logic [DATA_W-1:0]  buf_data [NUM_SRC];
    logic [TAG_W-1:0]   win_tag;
    logic [DATA_W-1:0]  win_data;

    // Masking requests during flush keeps rr_ptr and the CDB register untouched.
    assign req       = flush ? '0 : full;
    assign src_ready = flush ? '0 : (~full | grant);
    assign take      = src_valid & src_ready;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_tag[i]  <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (flush) begin
                    full[i] <= 1'b0;
                end else if (take[i]) begin
                    // A tag-0 result is acknowledged but never occupies the buffer.
                    full[i]     <= (src_tag[i*TAG_W +: TAG_W] != TAG_W'(TAG_NONE));
                    buf_tag[i]  <= src_tag[i*TAG_W +: TAG_W];
                    buf_data[i] <= src_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        win_tag  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                win_tag  = win_tag  | buf_tag[i];
                win_data = win_data | buf_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= |grant;
            if (|grant) begin
                cdb_tag  <= win_tag;
                cdb_data <= win_data;
            end
        end
    end

`ifdef CDB_PERF_EN
    logic multi_full;
    assign multi_full = ($countones(full) > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bcast    <= '0;
            perf_conflict <= '0;
        end else if (flush) begin
            perf_bcast    <= '0;
            perf_conflict <= '0;
        end else begin
            if (cdb_valid && perf_bcast != 16'hFFFF) begin
                perf_bcast <= perf_bcast + 16'd1;
            end
            if (multi_full && perf_conflict != 16'hFFFF) begin
                perf_conflict <= perf_conflict + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-cycle vector table plus a reset-mid-broadcast sequence.
module tb_cdb_arbiter;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [3:0]   src_valid;
    logic [15:0]  src_tag;
    logic [127:0] src_data;
    logic [3:0]   src_ready;
    logic         cdb_valid;
    logic [3:0]   cdb_tag;
    logic [31:0]  cdb_data;
`ifdef CDB_PERF_EN
    logic [15:0]  perf_bcast;
    logic [15:0]  perf_conflict;
`endif

    cdb_arbiter #(.NUM_SRC(4), .TAG_W(4), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .src_valid     (src_valid),
        .src_tag       (src_tag),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data)
`ifdef CDB_PERF_EN
        ,
        .perf_bcast    (perf_bcast),
        .perf_conflict (perf_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         fl;
        logic [3:0]   vld;
        logic [15:0]  tag;
        logic [127:0] data;
        logic [3:0]   rdy;
        logic         cv;
        logic [3:0]   ct;
        logic [31:0]  cd;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic fl, input logic [3:0] vld, input logic [15:0] tag,
                                input logic [127:0] data, input logic [3:0] rdy,
                                input logic cv, input logic [3:0] ct, input logic [31:0] cd);
        vec_t v;
        v.fl = fl; v.vld = vld; v.tag = tag; v.data = data;
        v.rdy = rdy; v.cv = cv; v.ct = ct; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [3:0] vld, input logic [15:0] tag, input logic [127:0] data);
        flush     = fl;
        src_valid = vld;
        src_tag   = tag;
        src_data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] z;
        bit           seen;
        z = '0;

        // contention: tags 1..4 on src0..3 at once, rr_ptr starts at 0
        tbl[0]  = mk(0, 4'b1111, 16'h4321, {32'h44, 32'h33, 32'h22, 32'h11}, 4'b1111, 0, 4'h0, 32'h00);
        tbl[1]  = mk(0, 4'b0000, 16'h0000, z, 4'b0001, 0, 4'h0, 32'h00);
        tbl[2]  = mk(0, 4'b0000, 16'h0000, z, 4'b0011, 1, 4'h1, 32'h11);
        tbl[3]  = mk(0, 4'b0000, 16'h0000, z, 4'b0111, 1, 4'h2, 32'h22);
        tbl[4]  = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 1, 4'h3, 32'h33);
        tbl[5]  = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 1, 4'h4, 32'h44);
        // tag 0 on src1: acknowledged, never broadcast
        tbl[6]  = mk(0, 4'b0010, 16'h0000, {32'h0, 32'h0, 32'h55, 32'h0}, 4'b1111, 0, 4'h4, 32'h44);
        tbl[7]  = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 0, 4'h4, 32'h44);
        tbl[8]  = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 0, 4'h4, 32'h44);
        // fairness: src0 (tag 6) and src2 (tag 7) held valid
        tbl[9]  = mk(0, 4'b0101, 16'h0706, {32'h0, 32'h70, 32'h0, 32'h60}, 4'b1111, 0, 4'h4, 32'h44);
        tbl[10] = mk(0, 4'b0101, 16'h0706, {32'h0, 32'h70, 32'h0, 32'h60}, 4'b1011, 0, 4'h4, 32'h44);
        tbl[11] = mk(0, 4'b0101, 16'h0706, {32'h0, 32'h70, 32'h0, 32'h60}, 4'b1110, 1, 4'h6, 32'h60);
        tbl[12] = mk(0, 4'b0101, 16'h0706, {32'h0, 32'h70, 32'h0, 32'h60}, 4'b1011, 1, 4'h7, 32'h70);
        tbl[13] = mk(0, 4'b0101, 16'h0706, {32'h0, 32'h70, 32'h0, 32'h60}, 4'b1110, 1, 4'h6, 32'h60);
        tbl[14] = mk(0, 4'b0000, 16'h0000, z, 4'b1011, 1, 4'h7, 32'h70);
        tbl[15] = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 1, 4'h6, 32'h60);
        tbl[16] = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 1, 4'h7, 32'h70);
        // single: src0 tag 3 data 0xAA, broadcast two cycles later
        tbl[17] = mk(0, 4'b0001, 16'h0003, {32'h0, 32'h0, 32'h0, 32'hAA}, 4'b1111, 0, 4'h7, 32'h70);
        tbl[18] = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 0, 4'h7, 32'h70);
        tbl[19] = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 1, 4'h3, 32'hAA);
        // flush with three buffers full and a src3 tag-5 handshake attempt
        tbl[20] = mk(0, 4'b0111, 16'h0A98, {32'h0, 32'hA0, 32'h90, 32'h80}, 4'b1111, 0, 4'h3, 32'hAA);
        tbl[21] = mk(1, 4'b1000, 16'h5000, {32'h5555, 32'h0, 32'h0, 32'h0}, 4'b0000, 0, 4'h3, 32'hAA);
        tbl[22] = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 0, 4'h3, 32'hAA);
        // rr_ptr (=1) survived the flush: src1 wins over src0
        tbl[23] = mk(0, 4'b0011, 16'h00B2, {32'h0, 32'h0, 32'hB0, 32'h22}, 4'b1111, 0, 4'h3, 32'hAA);
        tbl[24] = mk(0, 4'b0000, 16'h0000, z, 4'b1110, 0, 4'h3, 32'hAA);
        tbl[25] = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 1, 4'hB, 32'hB0);
        tbl[26] = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 1, 4'h2, 32'h22);
        tbl[27] = mk(0, 4'b0000, 16'h0000, z, 4'b1111, 0, 4'h2, 32'h22);

        rst_n = 1'b0;
        drive(0, 4'b0000, 16'h0000, z);
        #1;
        chk("rst_ready", -1, 32'(src_ready), 32'hF);
        chk("rst_cvld",  -1, 32'(cdb_valid), 32'h0);
        chk("rst_ctag",  -1, 32'(cdb_tag),   32'h0);
        chk("rst_cdata", -1, cdb_data,       32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].fl, tbl[i].vld, tbl[i].tag, tbl[i].data);
            #1;
            chk("ready", i, 32'(src_ready), 32'(tbl[i].rdy));
            chk("cvld",  i, 32'(cdb_valid), 32'(tbl[i].cv));
            chk("ctag",  i, 32'(cdb_tag),   32'(tbl[i].ct));
            chk("cdata", i, cdb_data,       tbl[i].cd);
        end

        // reset mid-broadcast, with src0 and src2 still waiting (rr_ptr = 1 here)
        @(negedge clk);
        drive(0, 4'b0111, 16'h0654, {32'h0, 32'h66, 32'h55, 32'h44});
        @(negedge clk);
        drive(0, 4'b0000, 16'h0000, z);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (cdb_valid) seen = 1'b1;
        end
        chk("t1_wait_bcast", 0, 32'(seen), 32'h1);
        chk("t1_pre_ready",  0, 32'(src_ready), 32'hE);
        chk("t1_pre_ctag",   0, 32'(cdb_tag),   32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_cvld",  0, 32'(cdb_valid), 32'h0);
        chk("t1_ctag",  0, 32'(cdb_tag),   32'h0);
        chk("t1_cdata", 0, cdb_data,       32'h0);
        chk("t1_ready", 0, 32'(src_ready), 32'hF);

        // after reset rr_ptr is 0 again: src0 beats src3
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 4'b1001, 16'h1002, {32'h10, 32'h0, 32'h0, 32'h20});
        #1;
        chk("t1_post_ready", 0, 32'(src_ready), 32'hF);
        @(negedge clk);
        drive(0, 4'b0000, 16'h0000, z);
        #1;
        chk("t1_post_cvld", 0, 32'(cdb_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("t1_post_ctag", 1, 32'(cdb_tag),   32'h2);
        chk("t1_post_cdat", 1, cdb_data,       32'h20);
        @(negedge clk);
        #1;
        chk("t1_post_ctag", 2, 32'(cdb_tag),   32'h1);
        chk("t1_post_cdat", 2, cdb_data,       32'h10);
        chk("t1_post_cvld", 2, 32'(cdb_valid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
